// File: rtl/fb_access_ctrl.sv
// fb_access_ctrl: shares a single-port framebuffer between VGA scanout, a buffered pixel writer and a fill engine.
module fb_access_ctrl #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int OFF_X = 160,
    parameter int OFF_Y = 120,
    parameter logic [7:0] BG_COLOR = 8'h00,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  next_x,
    input  logic [9:0]  next_y,
    output logic [7:0]  color_out,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [8:0]  wr_x,
    input  logic [7:0]  wr_y,
    input  logic [7:0]  wr_data,
    output logic        wr_dropped,
    output logic [4:0]  fifo_level,
    input  logic        clr_start,
    input  logic [7:0]  clr_color,
    output logic        clr_busy,
    output logic        clr_done,
    output logic [16:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [9:0] X0 = 10'(OFF_X);
    localparam logic [9:0] X1 = 10'(OFF_X + IMG_W);
    localparam logic [9:0] Y0 = 10'(OFF_Y);
    localparam logic [9:0] Y1 = 10'(OFF_Y + IMG_H);
    localparam logic [16:0] LAST = 17'(IMG_W * IMG_H - 1);
    typedef enum logic {IDLE, FILL} state_t;
    state_t state, state_nx;
    logic in_win, win_d1, win_d2, push, store, pop, fill_slot, last;
    logic [16:0] rd_addr, pop_addr, fill_cnt;
    logic [7:0] clr_val;
    logic [8:0] fx [FIFO_DEPTH];
    logic [7:0] fy [FIFO_DEPTH];
    logic [7:0] fd [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    always_comb begin
        in_win    = next_x >= X0 && next_x < X1 && next_y >= Y0 && next_y < Y1;
        rd_addr   = 17'(next_y - Y0) * 17'(IMG_W) + 17'(next_x - X0);
        pop_addr  = 17'(fy[rp]) * 17'(IMG_W) + 17'(fx[rp]);
        wr_ready  = fifo_level != 5'(FIFO_DEPTH);
        push      = wr_valid && wr_ready;
        store     = push && wr_x < 9'(IMG_W) && 9'(wr_y) < 9'(IMG_H);
        fill_slot = !in_win && state == FILL;
        pop       = !in_win && state != FILL && fifo_level != 5'd0;
        last      = fill_slot && fill_cnt == LAST;
        clr_busy  = state == FILL;
        state_nx  = state == IDLE ? (clr_start ? FILL : IDLE) : (last ? IDLE : FILL);
    end
    // FIFO storage needs no reset; occupancy and pointers define validity
    always_ff @(posedge clock) begin
        if (store) begin
            fx[wp] <= wr_x;
            fy[wp] <= wr_y;
            fd[wp] <= wr_data;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            win_d1     <= 1'b0;
            win_d2     <= 1'b0;
            color_out  <= BG_COLOR;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            wr_dropped <= 1'b0;
            clr_done   <= 1'b0;
            fifo_level <= '0;
            wp         <= '0;
            rp         <= '0;
            fill_cnt   <= '0;
            clr_val    <= '0;
        end else begin
            state      <= state_nx;
            win_d1     <= in_win;
            win_d2     <= win_d1;
            color_out  <= win_d2 ? ram_rdata : BG_COLOR;
            wr_dropped <= push && !store;
            clr_done   <= last;
            fifo_level <= fifo_level + 5'(store) - 5'(pop);
            wp         <= wp + AW'(store);
            rp         <= rp + AW'(pop);
            if (state == IDLE && clr_start) begin
                fill_cnt <= '0;
                clr_val  <= clr_color;
            end else if (fill_slot) begin
                fill_cnt <= fill_cnt + 17'd1;
            end
            // scanout owns the slot whenever the next pixel is inside the image
            if (in_win) begin
                ram_addr <= rd_addr;
                ram_we   <= 1'b0;
            end else if (fill_slot) begin
                ram_addr  <= fill_cnt;
                ram_wdata <= clr_val;
                ram_we    <= 1'b1;
            end else if (pop) begin
                ram_addr  <= pop_addr;
                ram_wdata <= fd[rp];
                ram_we    <= 1'b1;
            end else begin
                ram_we <= 1'b0;
            end
        end
    end
endmodule
